// File: rtl/hazard_ctrl_pipe.sv
// Control pipeline ID->EX->MEM->WB with hazard stall, branch flush and operand forwarding; 1/2/3-cycle latency D->E/M/W.
// Build with HAZARD_FWD_EN for EX forwarding (stall on load-use only); without it, stall on any RAW against EX or MEM.
module hazard_ctrl_pipe #(
    parameter int ZERO_REG = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ALUSrc_D,
    input  logic       MemtoReg_D,
    input  logic       RegWrite_D,
    input  logic       MemRead_D,
    input  logic       MemWrite_D,
    input  logic       Branch_D,
    input  logic [1:0] ALUOp_D,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rd_D,
    input  logic       PCSrc_M,
    output logic       ALUSrc_E,
    output logic [1:0] ALUOp_E,
    output logic       MemRead_M,
    output logic       MemWrite_M,
    output logic       Branch_M,
    output logic       RegWrite_W,
    output logic       MemtoReg_W,
    output logic [4:0] rd_W,
    output logic       stall,
    output logic       flush_D,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB
);
    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic       MemtoReg_E, RegWrite_E, MemRead_E, MemWrite_E, Branch_E;
    logic [4:0] rd_E;
    logic       MemtoReg_M, RegWrite_M;
    logic [4:0] rd_M;

    logic hazard;
    logic dep_e;
    logic kill_e;
    logic kill_m;

    assign dep_e   = (rd_E != ZR) && ((rd_E == rs1_D) || (rd_E == rs2_D));
    // A taken branch squashes the stalled instruction anyway, so it wins over stall.
    assign stall   = hazard & ~PCSrc_M;
    assign flush_D = PCSrc_M;
    assign kill_e  = !reset || PCSrc_M || hazard;
    assign kill_m  = !reset || PCSrc_M;

`ifdef HAZARD_FWD_EN
    logic [4:0] rs1_E, rs2_E;

    assign hazard = MemRead_E & dep_e;

    assign ForwardA = (RegWrite_M && (rd_M != ZR) && (rd_M == rs1_E)) ? 2'b10 :
                      (RegWrite_W && (rd_W != ZR) && (rd_W == rs1_E)) ? 2'b01 : 2'b00;
    assign ForwardB = (RegWrite_M && (rd_M != ZR) && (rd_M == rs2_E)) ? 2'b10 :
                      (RegWrite_W && (rd_W != ZR) && (rd_W == rs2_E)) ? 2'b01 : 2'b00;

    // Source fields are only consumed by the forwarding compare.
    always_ff @(posedge clk) begin
        if (kill_e) begin
            rs1_E <= 5'd0;
            rs2_E <= 5'd0;
        end else begin
            rs1_E <= rs1_D;
            rs2_E <= rs2_D;
        end
    end
`else
    logic dep_m;

    assign dep_m  = (rd_M != ZR) && ((rd_M == rs1_D) || (rd_M == rs2_D));
    assign hazard = (RegWrite_E & dep_e) | (RegWrite_M & dep_m);

    assign ForwardA = 2'b00;
    assign ForwardB = 2'b00;
`endif

    // ID/EX: bubble on reset, flush or hazard
    always_ff @(posedge clk) begin
        if (kill_e) begin
            ALUSrc_E   <= 1'b0;
            ALUOp_E    <= 2'b00;
            MemtoReg_E <= 1'b0;
            RegWrite_E <= 1'b0;
            MemRead_E  <= 1'b0;
            MemWrite_E <= 1'b0;
            Branch_E   <= 1'b0;
            rd_E       <= 5'd0;
        end else begin
            ALUSrc_E   <= ALUSrc_D;
            ALUOp_E    <= ALUOp_D;
            MemtoReg_E <= MemtoReg_D;
            RegWrite_E <= RegWrite_D;
            MemRead_E  <= MemRead_D;
            MemWrite_E <= MemWrite_D;
            Branch_E   <= Branch_D;
            rd_E       <= rd_D;
        end
    end

    // EX/MEM: a stall still lets the older instruction move on
    always_ff @(posedge clk) begin
        if (kill_m) begin
            MemtoReg_M <= 1'b0;
            RegWrite_M <= 1'b0;
            MemRead_M  <= 1'b0;
            MemWrite_M <= 1'b0;
            Branch_M   <= 1'b0;
            rd_M       <= 5'd0;
        end else begin
            MemtoReg_M <= MemtoReg_E;
            RegWrite_M <= RegWrite_E;
            MemRead_M  <= MemRead_E;
            MemWrite_M <= MemWrite_E;
            Branch_M   <= Branch_E;
            rd_M       <= rd_E;
        end
    end

    // MEM/WB: the branch itself sits in MEM and must still retire
    always_ff @(posedge clk) begin
        if (!reset) begin
            RegWrite_W <= 1'b0;
            MemtoReg_W <= 1'b0;
            rd_W       <= 5'd0;
        end else begin
            RegWrite_W <= RegWrite_M;
            MemtoReg_W <= MemtoReg_M;
            rd_W       <= rd_M;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: directed hazard scenarios plus random instruction streams against a stage-occupancy model.
module tb_hazard_ctrl_pipe;
    localparam logic [4:0] ZR = 5'd31;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int K_NOP = 0, K_ALU = 1, K_LD = 2, K_ST = 3, K_BR = 4;

    typedef struct packed {
        logic       alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic [1:0] aluop;
        logic [4:0] rs1, rs2, rd;
    } ins_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic pcsrc;
    ins_t d;

    logic       ALUSrc_E, MemRead_M, MemWrite_M, Branch_M, RegWrite_W, MemtoReg_W;
    logic       stall, flush_D;
    logic [1:0] ALUOp_E, ForwardA, ForwardB;
    logic [4:0] rd_W;

    hazard_ctrl_pipe #(.ZERO_REG(31)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUSrc_D   (d.alusrc),
        .MemtoReg_D (d.memtoreg),
        .RegWrite_D (d.regwrite),
        .MemRead_D  (d.memread),
        .MemWrite_D (d.memwrite),
        .Branch_D   (d.branch),
        .ALUOp_D    (d.aluop),
        .rs1_D      (d.rs1),
        .rs2_D      (d.rs2),
        .rd_D       (d.rd),
        .PCSrc_M    (pcsrc),
        .ALUSrc_E   (ALUSrc_E),
        .ALUOp_E    (ALUOp_E),
        .MemRead_M  (MemRead_M),
        .MemWrite_M (MemWrite_M),
        .Branch_M   (Branch_M),
        .RegWrite_W (RegWrite_W),
        .MemtoReg_W (MemtoReg_W),
        .rd_W       (rd_W),
        .stall      (stall),
        .flush_D    (flush_D),
        .ForwardA   (ForwardA),
        .ForwardB   (ForwardB)
    );

    wire [18:0] all_out = {ALUSrc_E, ALUOp_E, MemRead_M, MemWrite_M, Branch_M, RegWrite_W,
                           MemtoReg_W, rd_W, stall, flush_D, ForwardA, ForwardB};

    // Model: the instruction occupying each of EX, MEM, WB ('0 = empty slot)
    ins_t pe, pm, pw;
    int   n_cmp = 0, n_bad = 0, cyc_no = 0;
    logic exp_stall, obs_stall, obs_flush;
    logic [1:0] obs_fa, obs_fb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc_no, got, exp);
        end
    endtask

    function automatic logic reads(input ins_t r, input logic [4:0] x);
        return (x != ZR) && ((r.rs1 == x) || (r.rs2 == x));
    endfunction

    function automatic logic model_stall();
        logic s;
        if (FWD) s = pe.memread && reads(d, pe.rd);
        else     s = (pe.regwrite && reads(d, pe.rd)) || (pm.regwrite && reads(d, pm.rd));
        return s && !pcsrc;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] x);
        if (!FWD || x == ZR) return 2'b00;
        if (pm.regwrite && pm.rd == x) return 2'b10;
        if (pw.regwrite && pw.rd == x) return 2'b01;
        return 2'b00;
    endfunction

    function automatic ins_t mk(input int kind, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        ins_t r;
        r = '0;
        r.rs1 = rn;
        r.rs2 = rm;
        r.rd  = rd;
        case (kind)
            K_ALU:   begin r.regwrite = 1'b1; r.aluop = 2'b10; end
            K_LD:    begin r.alusrc = 1'b1; r.memtoreg = 1'b1; r.regwrite = 1'b1; r.memread = 1'b1; end
            K_ST:    begin r.alusrc = 1'b1; r.memwrite = 1'b1; end
            K_BR:    begin r.branch = 1'b1; r.aluop = 2'b01; end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] pick();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? ZR : 5'(k);
    endfunction

    // Drive one ID-stage slot for one cycle, check at the falling edge, advance the model at the rising edge.
    task automatic cyc(input ins_t nd, input logic np, input logic nr);
        d = nd;
        pcsrc = np;
        reset = nr;
        @(negedge clk);
        exp_stall = model_stall();
        obs_stall = stall;
        obs_flush = flush_D;
        obs_fa    = ForwardA;
        obs_fb    = ForwardB;
        chk("stall",      stall,      exp_stall);
        chk("flush_D",    flush_D,    pcsrc);
        chk("ForwardA",   ForwardA,   model_fwd(pe.rs1));
        chk("ForwardB",   ForwardB,   model_fwd(pe.rs2));
        chk("ALUSrc_E",   ALUSrc_E,   pe.alusrc);
        chk("ALUOp_E",    ALUOp_E,    pe.aluop);
        chk("MemRead_M",  MemRead_M,  pm.memread);
        chk("MemWrite_M", MemWrite_M, pm.memwrite);
        chk("Branch_M",   Branch_M,   pm.branch);
        chk("RegWrite_W", RegWrite_W, pw.regwrite);
        chk("MemtoReg_W", MemtoReg_W, pw.memtoreg);
        chk("rd_W",       rd_W,       pw.rd);
        @(posedge clk);
        if (!reset) begin
            pe = '0; pm = '0; pw = '0;
        end else begin
            pw = pm;
            pm = pcsrc ? '0 : pe;
            pe = (pcsrc || exp_stall) ? '0 : d;
        end
        cyc_no++;
        #1;
    endtask

    task automatic count_stalls(input ins_t x, output int n);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(x, 1'b0, 1'b1);
            if (!obs_stall) break;
            n++;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) cyc('0, 1'b0, 1'b1);
    endtask

    ins_t nxt;
    int   ns;

    initial begin
        reset = 1'b0;
        pcsrc = 1'b0;
        d     = '0;
        pe = '0; pm = '0; pw = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_out, 19'd0);
        cyc('0, 1'b0, 1'b1);

        // Load followed by a dependent ALU op
        cyc(mk(K_LD, 5'd1, ZR, ZR), 1'b0, 1'b1);
        count_stalls(mk(K_ALU, 5'd4, 5'd1, 5'd2), ns);
`ifdef HAZARD_FWD_EN
        chk("load_use_stalls", ns, 1);
`else
        chk("load_use_stalls", ns, 2);
`endif
        drain();

        // Load to XZR never stalls
        cyc(mk(K_LD, ZR, 5'd2, ZR), 1'b0, 1'b1);
        count_stalls(mk(K_ALU, 5'd4, ZR, 5'd2), ns);
        chk("xzr_no_stall", ns, 0);
        drain();

`ifdef HAZARD_FWD_EN
        cyc(mk(K_ALU, 5'd2, ZR, ZR), 1'b0, 1'b1);
        cyc(mk(K_ALU, 5'd5, 5'd2, 5'd2), 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        chk("fwd_exmem_A", obs_fa, 2'b10);
        chk("fwd_exmem_B", obs_fb, 2'b10);
        drain();
        cyc(mk(K_ALU, 5'd2, ZR, ZR), 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        cyc(mk(K_ALU, 5'd5, 5'd2, 5'd2), 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        chk("fwd_memwb_A", obs_fa, 2'b01);
        chk("fwd_memwb_B", obs_fb, 2'b01);
        drain();
`else
        cyc(mk(K_ALU, 5'd3, ZR, ZR), 1'b0, 1'b1);
        count_stalls(mk(K_ALU, 5'd5, ZR, 5'd3), ns);
        chk("raw_stalls", ns, 2);
        chk("raw_fwdA", obs_fa, 2'b00);
        chk("raw_fwdB", obs_fb, 2'b00);
        drain();
`endif

        // Taken branch in MEM coinciding with a load-use hazard in ID
        cyc(mk(K_BR, ZR, ZR, ZR), 1'b0, 1'b1);
        cyc(mk(K_LD, 5'd1, ZR, ZR), 1'b0, 1'b1);
        cyc(mk(K_ALU, 5'd4, 5'd1, ZR), 1'b1, 1'b1);
        chk("br_stall", obs_stall, 1'b0);
        chk("br_flush", obs_flush, 1'b1);
        chk("br_MemRead_M", MemRead_M, 1'b0);
        chk("br_MemWrite_M", MemWrite_M, 1'b0);
        chk("br_ALUOp_E", ALUOp_E, 2'b00);
        drain();

        // Reset while a store sits in MEM
        cyc(mk(K_ST, ZR, 5'd1, 5'd2), 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        chk("stur_in_M", MemWrite_M, 1'b1);
        cyc(mk(K_ALU, 5'd6, 5'd1, 5'd2), 1'b0, 1'b0);
        chk("reset_mid_op", all_out, 19'd0);
        cyc('0, 1'b0, 1'b1);

        // Random streams: stalled slot is held, a flushed slot becomes a nop
        nxt = mk($urandom_range(0, 4), pick(), pick(), pick());
        for (int i = 0; i < 600; i++) begin
            cyc(nxt, pm.branch && ($urandom_range(0, 1) == 1), $urandom_range(0, 79) != 0);
            if (reset && pcsrc) nxt = '0;
            else if (!exp_stall) nxt = mk($urandom_range(0, 4), pick(), pick(), pick());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
